aes_enc_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer. It accepts one plaintext block plus key through a valid/ready handshake, then performs one AES round per clock using the aes_ops datapath (sub_bytes, shift_rows, mix_columns, AddRoundKey XOR). Round keys are expanded on the fly alongside the state. The ciphertext is presented through a valid/ready output handshake. The block sits between the bus/DMA front-end and the aes_ops combinational stages.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_key_step.sv | 35 +++
 rtl/aes_ops.sv | 67 ++++++
 rtl/aes_enc_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_enc_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and byte-level helpers.
// Used by the encrypt controller, the key-step unit and the round stages.
// Layout: byte (row r, col c) sits at bits [32c+8r+7 : 32c+8r].
// Column c is the word at bits [32c+31 : 32c].
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_t;

  // The table is indexed directly by the 4-bit round counter.
  // Entry 0 and entries 11..15 are never used and are kept at zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 lives in the LSBs, so rotating left by one byte moves the
  // old byte 1 down to the bottom and byte 0 up to the top.
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[7:0], w[31:24], w[23:16], w[15:8]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one step of the AES-128 key schedule.
//   rk      in  128  current round key, word w_i at bits [32i+31:32i]
//   rcon    in  8    round constant for the key being produced
//   rk_next out 128  following round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot;
  aes_word_t t;
  aes_word_t n0, n1, n2, n3;

  assign w0  = rk[31:0];
  assign w1  = rk[63:32];
  assign w2  = rk[95:64];
  assign w3  = rk[127:96];
  assign rot = rot_word(w3);

  // SubWord: four independent S-box lookups on the rotated last word.
  assign t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  // The round constant only touches byte 0 of the first word.
  assign n0 = w0 ^ t ^ {24'h0, rcon};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_ops.sv
// aes_ops: the combinational AES round stages shared by the controllers.
//   sub_bytes   : state_in -> state_out, S-box on every byte
//   shift_rows  : state_in -> state_out, row r rotated left by r columns
//   mix_columns : state_in -> state_out, MixColumns on each column word
module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  always_comb begin
    state_out = '0;
    for (int k = 0; k < 16; k++) begin
      state_out[8*k +: 8] = sbox(state_in[8*k +: 8]);
    end
  end

endmodule

module shift_rows (
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  // Output byte (r, c) takes input byte (r, (c + r) mod 4).
  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        state_out[32*c + 8*r +: 8] = state_in[32*((c + r) % 4) + 8*r +: 8];
      end
    end
  end

endmodule

module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  logic [7:0] a0, a1, a2, a3;

  // Each column is multiplied by the fixed matrix rows {02 03 01 01}
  // rotated; 03*a is expanded as xtime(a) ^ a.
  always_comb begin
    state_out = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = state_in[32*c      +: 8];
      a1 = state_in[32*c + 8  +: 8];
      a2 = state_in[32*c + 16 +: 8];
      a3 = state_in[32*c + 24 +: 8];
      state_out[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      state_out[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      state_out[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      state_out[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

endmodule

// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl: iterative AES-128 encryption sequencer, one round per clock.
//   clk, rst            core clock, asynchronous active-high reset
//   in_valid/in_ready   job handshake carrying data_in (plaintext) and key_in
//   out_valid/out_ready result handshake carrying data_out (ciphertext)
//   busy                high whenever the FSM is not IDLE
//   round_o             current round counter, 0 in IDLE, ROUNDS in DONE
// ROUNDS (1..10) trims the round count for debug; the last round always
// skips MixColumns.
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy,
  output logic [3:0]   round_o
);

  if (ROUNDS < 1 || ROUNDS > 10) begin : g_rounds_check
    $error("aes_enc_ctrl: ROUNDS must lie in 1..10");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  aes_fsm_t   fsm_q;
  aes_state_t state_q;
  aes_state_t rk_q;
  logic [3:0] round_q;
  logic       out_valid_q;

  aes_state_t sb_out;
  aes_state_t sr_out;
  aes_state_t mc_out;
  aes_state_t rk_next;
  logic       accept;
  logic       last_round;

  sub_bytes u_sub_bytes (
    .state_in  (state_q),
    .state_out (sb_out)
  );

  shift_rows u_shift_rows (
    .state_in  (sb_out),
    .state_out (sr_out)
  );

  mix_columns u_mix_columns (
    .state_in  (sr_out),
    .state_out (mc_out)
  );

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (RCON[round_q]),
    .rk_next (rk_next)
  );

  // Ready is held low during reset so nothing can slip in as rst drops.
  // In DONE a new job may enter on the same edge the result retires.
  assign in_ready   = !rst && ((fsm_q == IDLE) || (fsm_q == DONE && out_ready));
  assign accept     = in_valid && in_ready;
  assign last_round = (round_q == LAST_ROUND);

  assign out_valid = out_valid_q;
  assign data_out  = state_q;
  assign busy      = (fsm_q != IDLE);
  assign round_o   = round_q;

  // Sequencer: the initial AddRoundKey happens at accept, then each ROUND
  // cycle applies one full round with the key expanded in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q <= data_in ^ key_in;
            rk_q    <= key_in;
            round_q <= 4'd1;
            fsm_q   <= ROUND;
          end
        end

        ROUND: begin
          rk_q <= rk_next;
          if (last_round) begin
            state_q     <= sr_out ^ rk_next;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            state_q <= mc_out ^ rk_next;
            round_q <= round_q + 4'd1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q <= data_in ^ key_in;
              rk_q    <= key_in;
              round_q <= 4'd1;
              fsm_q   <= ROUND;
            end else begin
              round_q <= '0;
              fsm_q   <= IDLE;
            end
          end
        end

        default: begin
          fsm_q       <= IDLE;
          round_q     <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb_aes_enc_ctrl: directed test of aes_enc_ctrl against FIPS-197 vectors,
// covering latency, backpressure, back-to-back jobs, ignored requests while
// busy and asynchronous reset in the middle of a block.
module tb_aes_enc_ctrl;

  localparam logic [127:0] PT_B  = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] KEY_B = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] CT_B  = 128'h320b6a19978511dcfb09dc021d842539;
  localparam logic [127:0] PT_C  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY_C = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT_C  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;
  logic [3:0]   round_o;

  int checks;
  int errors;
  int cycles;
  logic [127:0] held;
  logic         seen_valid;

  aes_enc_ctrl #(.ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy),
    .round_o   (round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a job and hold it until it is accepted; returns 1ns after the
  // accepting edge with in_valid dropped.
  task automatic apply_stimulus(input logic [127:0] d, input logic [127:0] k);
    int n;
    data_in  = d;
    key_in   = k;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_output("accept ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (round_o !== r && n < 30) begin
      tick();
      n++;
    end
    check_output("reach round", round_o, r);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    key_in    = '0;

    $display("[TB] reset state");
    #2;
    check_output("rst in_ready", in_ready, 1'b0);
    check_output("rst out_valid", out_valid, 1'b0);
    check_output("rst busy", busy, 1'b0);
    check_output("rst round_o", round_o, 4'd0);
    check_output("rst data_out", data_out, '0);
    #10;
    rst = 1'b0;
    #1;
    check_output("idle in_ready", in_ready, 1'b1);

    $display("[TB] FIPS-197 App B with latency and backpressure");
    apply_stimulus(PT_B, KEY_B);
    check_output("B busy", busy, 1'b1);
    check_output("B round 1", round_o, 4'd1);
    wait_out_valid(cycles);
    check_output("B latency", 128'(cycles), 128'd10);
    check_output("B data", data_out, CT_B);
    check_output("B round_o done", round_o, 4'd10);
    check_output("B in_ready held", in_ready, 1'b0);
    held = data_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output("bp data stable", data_out, held);
      check_output("bp out_valid", out_valid, 1'b1);
      check_output("bp in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_output("done ready w/ out_ready", in_ready, 1'b1);
    tick();
    out_ready = 1'b0;
    check_output("retire out_valid", out_valid, 1'b0);
    check_output("retire in_ready", in_ready, 1'b1);
    check_output("retire busy", busy, 1'b0);
    check_output("retire round_o", round_o, 4'd0);

    $display("[TB] FIPS-197 App C.1");
    apply_stimulus(PT_C, KEY_C);
    wait_out_valid(cycles);
    check_output("C latency", 128'(cycles), 128'd10);
    check_output("C data", data_out, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("C retired", out_valid, 1'b0);

    $display("[TB] back-to-back jobs");
    out_ready = 1'b1;
    data_in   = PT_B;
    key_in    = KEY_B;
    in_valid  = 1'b1;
    tick();
    data_in = PT_C;
    key_in  = KEY_C;
    check_output("b2b first accepted", round_o, 4'd1);
    check_output("b2b ready in round", in_ready, 1'b0);
    wait_out_valid(cycles);
    check_output("b2b first latency", 128'(cycles), 128'd10);
    check_output("b2b first data", data_out, CT_B);
    check_output("b2b ready at done", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_output("b2b retire valid", out_valid, 1'b0);
    check_output("b2b second busy", busy, 1'b1);
    check_output("b2b second round", round_o, 4'd1);
    wait_out_valid(cycles);
    check_output("b2b spacing", 128'(cycles + 1), 128'd11);
    check_output("b2b second data", data_out, CT_C);
    tick();
    out_ready = 1'b0;
    check_output("b2b idle", busy, 1'b0);

    $display("[TB] request ignored while busy");
    apply_stimulus(PT_B, KEY_B);
    wait_round(4'd5);
    check_output("busy not ready", in_ready, 1'b0);
    data_in  = PT_C;
    key_in   = KEY_C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(cycles);
    check_output("ignore data", data_out, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    check_output("ignore no extra job", busy, 1'b0);
    check_output("ignore no extra valid", out_valid, 1'b0);

    $display("[TB] reset in the middle of a block");
    apply_stimulus(PT_B, KEY_B);
    wait_round(4'd6);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid rst out_valid", out_valid, 1'b0);
    check_output("mid rst busy", busy, 1'b0);
    check_output("mid rst round_o", round_o, 4'd0);
    check_output("mid rst data_out", data_out, '0);
    check_output("mid rst in_ready", in_ready, 1'b0);
    #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check_output("mid rst no pulse", seen_valid, 1'b0);
    check_output("mid rst idle", busy, 1'b0);
    apply_stimulus(PT_B, KEY_B);
    wait_out_valid(cycles);
    check_output("post rst latency", 128'(cycles), 128'd10);
    check_output("post rst data", data_out, CT_B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
